ascon_serial_host: RTL and testbench
====================================

Name: ascon_serial_host

Overview:
- Host-side counterpart of the bit-serial Ascon core interface.
- Accepts one parallel job: key, nonce, associated data and plaintext, each as three shares, plus seven 64-bit randomness words.
- Resets the core, shifts every field out MSB-first on the serial share lanes, and starts encryption.
- Deserialises the core's LSB-first ciphertext/tag streams back into parallel words and presents them with a valid/ready handshake.

Parameters:
- K, 128, key width (bits)
- L, 80, associated-data width
- Y, 80, plaintext/ciphertext width
- TIMEOUT, 4096, cycles to wait for core ready before flagging an error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- job_valid  in  1  job offered
- job_ready  out  1  host idle, can accept a job
- key_in  in  3*K  packed {share2,share1,share0}
- nonce_in  in  384  packed {share2,share1,share0}
- ad_in  in  3*L  packed shares
- pt_in  in  3*Y  packed shares
- rnd_in  in  448  packed {r6..r0}, 64 bits each
- core_rst  out  1  synchronous reset pulse to the core
- key_so  out  3  serial key lanes
- nonce_so  out  3  serial nonce lanes
- ad_so  out  3  serial AD lanes
- pt_so  out  3  serial PT lanes
- r_so  out  7  serial randomness lanes
- enc_start_so  out  1  encryption start request
- enc_ready_si  in  1  core encryption ready
- ct_si  in  1  serial ciphertext, LSB-first
- tag_si  in  1  serial tag, LSB-first
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- ct_out  out  Y  ciphertext
- tag_out  out  128  tag
- err  out  1  timeout flag, valid with res_valid

Behaviour:
- Reset values: all outputs 0, except job_ready=1 (state IDLE). Reset is asynchronous and may occur in any state; the host returns to IDLE with no result.
- All outputs are registered.
- States: IDLE -> CRST -> SHIFT -> START -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - job_ready=1.
  - On job_valid&job_ready, latch all inputs into shadow registers and go to CRST.
  - Input changes after acceptance have no effect.
- CRST:
  - core_rst=1 for exactly one cycle; all lanes 0.
  - Clear cycle counter c; go to SHIFT.
- SHIFT:
  - Lasts SHIFT_LEN = max(K,128,L,Y)+2 cycles, c = 0..SHIFT_LEN-1.
  - For a field of width w, each lane s carries share s bit (w-1-c) when c<w, else 0.
  - Randomness lanes use w=64.
  - All lanes advance together. On c=SHIFT_LEN-1, go to START.
- START:
  - enc_start_so=1, held until enc_ready_si is sampled 1.
  - The watchdog counts START cycles. On reaching TIMEOUT: set err=1, drop enc_start_so, go to DONE with ct_out/tag_out=0.
- CAPTURE:
  - Entered on the edge that samples enc_ready_si=1; enc_start_so drops on the same edge.
  - The core's first serial bit is visible in the following cycle.
  - Capture counter n = 0..127, one bit per edge: tag_out[n] <= tag_si, and ct_out[n] <= ct_si only while n<Y.
  - After n=127, go to DONE.
  - enc_ready_si deasserting during CAPTURE is ignored.
- DONE:
  - res_valid=1; outputs stable.
  - On res_valid&res_ready: res_valid=0, err cleared, go to IDLE. job_ready rises the next cycle; back-to-back jobs are not overlapped.
- Width rules:
  - c, n and the watchdog counter are wide enough for SHIFT_LEN, 128 and TIMEOUT respectively. Nothing wraps: counters saturate by leaving their state.
  - Y>128 is illegal (elaboration assertion).
- Latency, job accept to res_valid: 1 + SHIFT_LEN + (START cycles) + 128 + 1.

Optional Feature:
- Macro ASCON_HOST_DECRYPT_EN.
- Defined:
  - Adds ports mode_in (1, latched with the job; 1=decrypt), dec_start_so, dec_ready_si, auth_si, and auth_out (Y-width ct_out reused as recovered plaintext).
  - In decrypt mode, START drives dec_start_so and waits on dec_ready_si, with the same watchdog.
  - CAPTURE samples the serial plaintext/decryption-tag streams identically.
  - auth_out is latched from auth_si on the CAPTURE entry edge.
- Undefined: encrypt only; the extra ports do not exist.

Decomposition:
- Package ascon_host_pkg:
  - state enum {IDLE,CRST,SHIFT,START,CAPTURE,DONE}
  - function max4 for SHIFT_LEN
  - constants NONCE_W=128, TAG_W=128, RND_W=64, RND_LANES=7
- One sub-module, ascon_host_piso:
  - Parameterised width W, three-share parallel-in/serial-out lane with a zero tail after W bits.
  - Instantiated per field.

Test Plan:
- Reset mid-SHIFT (assert rst at c=40) -> all outputs 0 immediately, job_ready=1; the next job replays from CRST with core_rst pulse width 1.
- Default params, key=0x000102..0F, nonce=0x0..0F, AD/PT 80-bit known vectors -> key_so[0] emits bit127 first; lanes zero from c=128 (key) and c=80 (AD/PT); SHIFT lasts 130 cycles; ct_out/tag_out match the Ascon-128 golden vector when run against the core.
- Core model asserting enc_ready 7 cycles into START, streaming ct=0xA5..., tag=0xDEAD... LSB-first one cycle later -> ct_out/tag_out bit-exact; enc_start_so low from the ready edge.
- enc_ready never asserted, TIMEOUT=16 -> res_valid after 16 START cycles with err=1 and ct_out=tag_out=0.
- res_ready held low 10 cycles in DONE -> res_valid and outputs stable; job_valid ignored (job_ready=0); accepted one cycle after the handshake.
- With ASCON_HOST_DECRYPT_EN, mode_in=1 and auth_si=0 at ready -> dec_start_so used (enc_start_so stays 0), auth_out=0.

Source files
------------

// File: rtl/ascon_host_pkg.sv
// ascon_host_pkg: shared states, widths and helpers for the Ascon serial host
package ascon_host_pkg;
  typedef enum logic [2:0] {IDLE, CRST, SHIFT, START, CAPTURE, DONE} state_e;
  localparam int NONCE_W = 128;
  localparam int TAG_W = 128;
  localparam int RND_W = 64;
  localparam int RND_LANES = 7;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > d) ? m : d;
  endfunction
endpackage

// File: rtl/ascon_host_piso.sv
// ascon_host_piso: N-lane parallel-in/serial-out, MSB-first, zero tail once W bits are out
module ascon_host_piso #(
  parameter int W = 64,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [N*W-1:0] par_i,
  output logic [N-1:0] ser_o
);
  logic [N-1:0][W-1:0] sr_q, sr_d;
  logic [N-1:0] ser_q, ser_d;
  assign ser_o = ser_q;
  // each lane emits its MSB and shifts in a zero, so the tail after W bits is 0
  always_comb begin
    sr_d = load_i ? par_i : sr_q;
    ser_d = '0;
    for (int s = 0; s < N; s++) begin
      ser_d[s] = shift_i ? sr_q[s][W-1] : 1'b0;
      if (shift_i) sr_d[s] = sr_q[s] << 1;
    end
  end
  // shadow shift register and registered lane outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr_q <= '0;
      ser_q <= '0;
    end else begin
      sr_q <= sr_d;
      ser_q <= ser_d;
    end
endmodule

// File: rtl/ascon_serial_host.sv
// ascon_serial_host: serialises a masked job to a bit-serial Ascon core and collects ct/tag; ASCON_HOST_DECRYPT_EN adds decrypt mode
module ascon_serial_host
  import ascon_host_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 80,
  parameter int Y = 80,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [3*K-1:0]             key_in,
  input  logic [3*NONCE_W-1:0]       nonce_in,
  input  logic [3*L-1:0]             ad_in,
  input  logic [3*Y-1:0]             pt_in,
  input  logic [RND_LANES*RND_W-1:0] rnd_in,
`ifdef ASCON_HOST_DECRYPT_EN
  input  logic                       mode_in,
  output logic                       dec_start_so,
  input  logic                       dec_ready_si,
  input  logic                       auth_si,
  output logic                       auth_out,
`endif
  output logic                       core_rst,
  output logic [2:0]                 key_so,
  output logic [2:0]                 nonce_so,
  output logic [2:0]                 ad_so,
  output logic [2:0]                 pt_so,
  output logic [RND_LANES-1:0]       r_so,
  output logic                       enc_start_so,
  input  logic                       enc_ready_si,
  input  logic                       ct_si,
  input  logic                       tag_si,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [Y-1:0]               ct_out,
  output logic [TAG_W-1:0]           tag_out,
  output logic                       err
);
  localparam int SHIFT_LEN = max4(K, NONCE_W, L, Y) + 2;
  localparam int CW = $clog2(SHIFT_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SHIFT_LEN - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

  if (Y > TAG_W || Y < 2) begin : g_bad_y
    $error("ascon_serial_host: Y must lie in 2..128");
  end

  state_e state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [7:0] n_q, n_d;
  logic [WW-1:0] wd_q, wd_d;
  logic job_ready_q, job_ready_d, core_rst_q, core_rst_d, enc_start_q, enc_start_d;
  logic res_valid_q, res_valid_d, err_q, err_d;
  logic [Y-1:0] ct_q, ct_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic accept, shift, ready;

  assign accept = (state_q == IDLE) && job_valid;
  assign shift = (state_q == CRST) || (state_q == SHIFT && c_q != C_LAST);

`ifdef ASCON_HOST_DECRYPT_EN
  logic mode_q, mode_d, dec_start_q, dec_start_d, auth_q, auth_d;
  assign ready = mode_q ? dec_ready_si : enc_ready_si;
  assign enc_start_d = (state_d == START) && !mode_d;
  assign dec_start_d = (state_d == START) && mode_d;
  assign dec_start_so = dec_start_q;
  assign auth_out = auth_q;
`else
  assign ready = enc_ready_si;
  assign enc_start_d = state_d == START;
`endif

  assign job_ready_d = state_d == IDLE;
  assign core_rst_d = state_d == CRST;
  assign res_valid_d = state_d == DONE;

  assign job_ready = job_ready_q;
  assign core_rst = core_rst_q;
  assign enc_start_so = enc_start_q;
  assign res_valid = res_valid_q;
  assign err = err_q;
  assign ct_out = ct_q;
  assign tag_out = tag_q;

  ascon_host_piso #(.W(K)) u_key (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .par_i(key_in), .ser_o(key_so));
  ascon_host_piso #(.W(NONCE_W)) u_nonce (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .par_i(nonce_in), .ser_o(nonce_so));
  ascon_host_piso #(.W(L)) u_ad (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .par_i(ad_in), .ser_o(ad_so));
  ascon_host_piso #(.W(Y)) u_pt (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .par_i(pt_in), .ser_o(pt_so));
  ascon_host_piso #(.W(RND_W), .N(RND_LANES)) u_rnd (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .par_i(rnd_in), .ser_o(r_so));

  // job sequencing: counters leave their state instead of wrapping; results arrive LSB-first
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    n_d = n_q;
    wd_d = wd_q;
    err_d = err_q;
    ct_d = ct_q;
    tag_d = tag_q;
`ifdef ASCON_HOST_DECRYPT_EN
    mode_d = mode_q;
    auth_d = auth_q;
`endif
    case (state_q)
      IDLE: if (job_valid) begin
        state_d = CRST;
        err_d = 1'b0;
        ct_d = '0;
        tag_d = '0;
`ifdef ASCON_HOST_DECRYPT_EN
        mode_d = mode_in;
        auth_d = 1'b0;
`endif
      end
      CRST: begin
        state_d = SHIFT;
        c_d = '0;
      end
      SHIFT: if (c_q == C_LAST) begin
        state_d = START;
        wd_d = '0;
      end else c_d = c_q + 1'b1;
      START: if (ready) begin
        state_d = CAPTURE;
        n_d = '0;
`ifdef ASCON_HOST_DECRYPT_EN
        auth_d = auth_si;
`endif
      end else if (wd_q == W_LAST) begin
        state_d = DONE;
        err_d = 1'b1;
      end else wd_d = wd_q + 1'b1;
      CAPTURE: begin
        tag_d = {tag_si, tag_q[TAG_W-1:1]};
        if (n_q < 8'(Y)) ct_d = {ct_si, ct_q[Y-1:1]};
        if (n_q == 8'd127) state_d = DONE;
        else n_d = n_q + 1'b1;
      end
      DONE: if (res_ready) begin
        state_d = IDLE;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counters and every output are registered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      n_q <= '0;
      wd_q <= '0;
      job_ready_q <= 1'b1;
      core_rst_q <= 1'b0;
      enc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      err_q <= 1'b0;
      ct_q <= '0;
      tag_q <= '0;
`ifdef ASCON_HOST_DECRYPT_EN
      mode_q <= 1'b0;
      dec_start_q <= 1'b0;
      auth_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      n_q <= n_d;
      wd_q <= wd_d;
      job_ready_q <= job_ready_d;
      core_rst_q <= core_rst_d;
      enc_start_q <= enc_start_d;
      res_valid_q <= res_valid_d;
      err_q <= err_d;
      ct_q <= ct_d;
      tag_q <= tag_d;
`ifdef ASCON_HOST_DECRYPT_EN
      mode_q <= mode_d;
      dec_start_q <= dec_start_d;
      auth_q <= auth_d;
`endif
    end
endmodule

// File: tb/tb_ascon_serial_host.sv
// tb_ascon_serial_host: directed bench for ascon_serial_host with a small serial core model
module tb_ascon_serial_host;
  localparam int K = 128, L = 80, Y = 80, TO = 16, SL = 130;
  logic clk = 0, rst = 1, job_valid = 0, res_ready = 0;
  logic enc_ready_si = 0, ct_si = 0, tag_si = 0;
  logic [3*K-1:0] key_in = '0;
  logic [383:0] nonce_in = '0;
  logic [3*L-1:0] ad_in = '0;
  logic [3*Y-1:0] pt_in = '0;
  logic [447:0] rnd_in = '0;
  logic job_ready, core_rst, enc_start_so, res_valid, err;
  logic [2:0] key_so, nonce_so, ad_so, pt_so;
  logic [6:0] r_so;
  logic [Y-1:0] ct_out;
  logic [127:0] tag_out;
`ifdef ASCON_HOST_DECRYPT_EN
  logic mode_in = 0, dec_ready_si = 0, auth_si = 0, dec_start_so, auth_out;
  logic use_dec = 0, auth_set = 0;
`endif
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, cr_cnt = 0, es_cnt = 0;
  logic st_after, rv_early;
  logic [129:0] obs_k[3], obs_n[3], obs_a[3], obs_p[3], obs_r[7];
  logic [3*K-1:0] kref;
  logic [383:0] nref;
  logic [3*L-1:0] aref;
  logic [3*Y-1:0] pref;
  logic [447:0] rref;

  ascon_serial_host #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .pt_in(pt_in), .rnd_in(rnd_in),
`ifdef ASCON_HOST_DECRYPT_EN
    .mode_in(mode_in), .dec_start_so(dec_start_so), .dec_ready_si(dec_ready_si),
    .auth_si(auth_si), .auth_out(auth_out),
`endif
    .core_rst(core_rst), .key_so(key_so), .nonce_so(nonce_so), .ad_so(ad_so), .pt_so(pt_so),
    .r_so(r_so), .enc_start_so(enc_start_so), .enc_ready_si(enc_ready_si), .ct_si(ct_si),
    .tag_si(tag_si), .res_valid(res_valid), .res_ready(res_ready), .ct_out(ct_out),
    .tag_out(tag_out), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic set_inputs(input logic [7:0] sd);
    for (int s = 0; s < 3; s++) begin
      key_in[s*128 +: 128] = {16{sd + 8'(s)}};
      nonce_in[s*128 +: 128] = {16{sd + 8'(s + 3)}};
      ad_in[s*80 +: 80] = {10{sd + 8'(s + 6)}};
      pt_in[s*80 +: 80] = {10{sd + 8'(s + 9)}};
    end
    for (int i = 0; i < 7; i++) rnd_in[i*64 +: 64] = {8{sd + 8'(i + 12)}};
  endtask

  task automatic save_refs();
    kref = key_in; nref = nonce_in; aref = ad_in; pref = pt_in; rref = rnd_in;
  endtask

  // offers the job while idle; returns at the CRST-cycle negedge
  task automatic send_job();
    @(negedge clk); job_valid = 1;
    @(negedge clk); job_valid = 0; acc_cyc = cyc;
  endtask

  // records every lane over the SHIFT window; returns at the first START negedge
  task automatic collect_shift();
    cr_cnt = int'(core_rst); es_cnt = 0;
    for (int c = 0; c < SL; c++) begin
      @(negedge clk);
      cr_cnt += int'(core_rst); es_cnt += int'(enc_start_so);
      for (int s = 0; s < 3; s++) begin
        obs_k[s] = {obs_k[s][128:0], key_so[s]};
        obs_n[s] = {obs_n[s][128:0], nonce_so[s]};
        obs_a[s] = {obs_a[s][128:0], ad_so[s]};
        obs_p[s] = {obs_p[s][128:0], pt_so[s]};
      end
      for (int s = 0; s < 7; s++) obs_r[s] = {obs_r[s][128:0], r_so[s]};
    end
    @(negedge clk);
  endtask

  // core model: raises ready in START cycle dly-1, then streams 128 bits LSB-first
  task automatic core_respond(input int dly, input logic [127:0] cs, input logic [127:0] ts);
    for (int i = 1; i < dly; i++) @(negedge clk);
`ifdef ASCON_HOST_DECRYPT_EN
    if (use_dec) begin dec_ready_si = 1; auth_si = auth_set; end else
`endif
    enc_ready_si = 1;
    rv_early = 0;
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      if (n == 0) st_after = enc_start_so;
      enc_ready_si = 0;
`ifdef ASCON_HOST_DECRYPT_EN
      dec_ready_si = 0; auth_si = ~auth_set;
`endif
      ct_si = cs[n]; tag_si = ts[n];
      rv_early |= res_valid;
    end
    @(negedge clk);
  endtask

  task automatic consume();
    res_ready = 1;
    @(negedge clk); res_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL rst_job_ready: got %b expected 1", job_ready); end
    checks++; if ({core_rst, enc_start_so, res_valid, err} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {core_rst, enc_start_so, res_valid, err}); end
    checks++; if ({key_so, nonce_so, ad_so, pt_so, r_so} !== 19'd0) begin errors++; $display("FAIL rst_lanes: got %h expected 0", {key_so, nonce_so, ad_so, pt_so, r_so}); end
    checks++; if ({ct_out, tag_out} !== 208'd0) begin errors++; $display("FAIL rst_result: got %h expected 0", {ct_out, tag_out}); end
    rst = 0;
  endtask

  task automatic test_shift();
    set_inputs(8'h11);
    key_in[127:0] = 128'h000102030405060708090A0B0C0D0E0F;
    key_in[383:256] = '1;
    nonce_in[127:0] = 128'h000102030405060708090A0B0C0D0E0F;
    ad_in[79:0] = 80'h4153434F4E2D41442121;
    pt_in[79:0] = 80'h48656C6C6F2041736F6E;
    save_refs();
    send_job();
    key_in = ~key_in; nonce_in = ~nonce_in; ad_in = ~ad_in; pt_in = ~pt_in; rnd_in = ~rnd_in;
    checks++; if ({core_rst, job_ready} !== 2'b10) begin errors++; $display("FAIL crst_state: got %b expected 10", {core_rst, job_ready}); end
    checks++; if ({key_so, nonce_so, ad_so, pt_so, r_so} !== 19'd0) begin errors++; $display("FAIL crst_lanes: got %h expected 0", {key_so, nonce_so, ad_so, pt_so, r_so}); end
    collect_shift();
    checks++; if (cr_cnt !== 1) begin errors++; $display("FAIL core_rst_width: got %0d expected 1", cr_cnt); end
    checks++; if (es_cnt !== 0 || enc_start_so !== 1'b1) begin errors++; $display("FAIL shift_len: start during shift %0d, start after %b, expected 0 and 1", es_cnt, enc_start_so); end
    checks++; if (obs_k[0][129:114] !== 16'h0001) begin errors++; $display("FAIL key0_first_bits: got %h expected 0001", obs_k[0][129:114]); end
    checks++; if (obs_a[0][49:0] !== 50'd0) begin errors++; $display("FAIL ad0_tail: got %h expected 0", obs_a[0][49:0]); end
    for (int s = 0; s < 3; s++) begin
      checks++; if (obs_k[s] !== {kref[s*128 +: 128], 2'b00}) begin errors++; $display("FAIL key_lane%0d: got %h expected %h", s, obs_k[s], {kref[s*128 +: 128], 2'b00}); end
      checks++; if (obs_n[s] !== {nref[s*128 +: 128], 2'b00}) begin errors++; $display("FAIL nonce_lane%0d: got %h expected %h", s, obs_n[s], {nref[s*128 +: 128], 2'b00}); end
      checks++; if (obs_a[s] !== {aref[s*80 +: 80], 50'd0}) begin errors++; $display("FAIL ad_lane%0d: got %h expected %h", s, obs_a[s], {aref[s*80 +: 80], 50'd0}); end
      checks++; if (obs_p[s] !== {pref[s*80 +: 80], 50'd0}) begin errors++; $display("FAIL pt_lane%0d: got %h expected %h", s, obs_p[s], {pref[s*80 +: 80], 50'd0}); end
    end
    for (int s = 0; s < 7; s++) begin
      checks++; if (obs_r[s] !== {rref[s*64 +: 64], 66'd0}) begin errors++; $display("FAIL rnd_lane%0d: got %h expected %h", s, obs_r[s], {rref[s*64 +: 64], 66'd0}); end
    end
  endtask

  task automatic test_capture();
    logic [79:0] ct;
    logic [127:0] tag;
    ct = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
    tag = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    core_respond(7, {48'hFFFF_FFFF_FFFF, ct}, tag);
    checks++; if (st_after !== 1'b0) begin errors++; $display("FAIL start_drop: got %b expected 0", st_after); end
    checks++; if (rv_early !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0", rv_early); end
    checks++; if ({res_valid, err, enc_start_so, job_ready} !== 4'b1000) begin errors++; $display("FAIL done_ctrl: got %b expected 1000", {res_valid, err, enc_start_so, job_ready}); end
    checks++; if (ct_out !== ct) begin errors++; $display("FAIL ct_out: got %h expected %h", ct_out, ct); end
    checks++; if (tag_out !== tag) begin errors++; $display("FAIL tag_out: got %h expected %h", tag_out, tag); end
    checks++; if (cyc - acc_cyc + 1 !== 267) begin errors++; $display("FAIL latency7: got %0d expected 267", cyc - acc_cyc + 1); end
  endtask

  task automatic test_done_stall();
    set_inputs(8'h2B);
    save_refs();
    job_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({res_valid, job_ready, core_rst} !== 3'b100 || ct_out !== 80'hA5A5_A5A5_A5A5_A5A5_A5A5 || tag_out !== 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF) begin errors++; $display("FAIL done_hold%0d: got %b/%h/%h expected 100/a5../deadbeef..", i, {res_valid, job_ready, core_rst}, ct_out, tag_out); end
    end
    res_ready = 1;
    @(negedge clk); res_ready = 0;
    checks++; if ({res_valid, job_ready} !== 2'b01) begin errors++; $display("FAIL handshake: got %b expected 01", {res_valid, job_ready}); end
    @(negedge clk); job_valid = 0; acc_cyc = cyc;
    checks++; if ({core_rst, job_ready} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got %b expected 10", {core_rst, job_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [79:0] ct;
    logic [127:0] tag;
    ct = 80'h0123_4567_89AB_CDEF_5AA5;
    tag = 128'h00FF00FF_12345678_9ABCDEF0_0F1E2D3C;
    collect_shift();
    checks++; if (cr_cnt !== 1) begin errors++; $display("FAIL b2b_core_rst: got %0d expected 1", cr_cnt); end
    for (int s = 0; s < 3; s++) begin
      checks++; if (obs_k[s] !== {kref[s*128 +: 128], 2'b00}) begin errors++; $display("FAIL b2b_key%0d: got %h expected %h", s, obs_k[s], {kref[s*128 +: 128], 2'b00}); end
      checks++; if (obs_p[s] !== {pref[s*80 +: 80], 50'd0}) begin errors++; $display("FAIL b2b_pt%0d: got %h expected %h", s, obs_p[s], {pref[s*80 +: 80], 50'd0}); end
    end
    core_respond(1, {48'd0, ct}, tag);
    checks++; if (ct_out !== ct || tag_out !== tag) begin errors++; $display("FAIL b2b_result: got %h/%h expected %h/%h", ct_out, tag_out, ct, tag); end
    checks++; if (cyc - acc_cyc + 1 !== 261) begin errors++; $display("FAIL latency1: got %0d expected 261", cyc - acc_cyc + 1); end
    consume();
  endtask

  task automatic test_timeout();
    int st_cnt, g;
    set_inputs(8'h5A);
    send_job();
    collect_shift();
    st_cnt = int'(enc_start_so); g = 0;
    while (res_valid !== 1'b1 && g < 40) begin
      @(negedge clk); g++;
      st_cnt += int'(enc_start_so);
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %b expected 1", res_valid); end
    checks++; if (st_cnt !== 16) begin errors++; $display("FAIL to_start_cycles: got %0d expected 16", st_cnt); end
    checks++; if ({err, enc_start_so} !== 2'b10) begin errors++; $display("FAIL to_err: got %b expected 10", {err, enc_start_so}); end
    checks++; if ({ct_out, tag_out} !== 208'd0) begin errors++; $display("FAIL to_result: got %h expected 0", {ct_out, tag_out}); end
    consume();
    checks++; if ({err, res_valid, job_ready} !== 3'b001) begin errors++; $display("FAIL to_clear: got %b expected 001", {err, res_valid, job_ready}); end
  endtask

  task automatic test_reset_mid_shift();
    set_inputs(8'hC3);
    key_in[383:256] = '1;
    save_refs();
    send_job();
    repeat (41) @(negedge clk);
    checks++; if (key_so[2] !== 1'b1) begin errors++; $display("FAIL pre_rst_lane: got %b expected 1", key_so[2]); end
    #1 rst = 1;
    #1;
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", job_ready); end
    checks++; if ({core_rst, enc_start_so, res_valid, err, key_so, nonce_so, ad_so, pt_so, r_so} !== 23'd0) begin errors++; $display("FAIL mid_rst_outputs: got %h expected 0", {core_rst, enc_start_so, res_valid, err, key_so, nonce_so, ad_so, pt_so, r_so}); end
    @(negedge clk); rst = 0;
    send_job();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL replay_crst: got %b expected 1", core_rst); end
    collect_shift();
    checks++; if (cr_cnt !== 1) begin errors++; $display("FAIL replay_core_rst_width: got %0d expected 1", cr_cnt); end
    checks++; if (obs_k[2] !== {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 2'b00}) begin errors++; $display("FAIL replay_key2: got %h expected all ones then 00", obs_k[2]); end
    checks++; if (obs_k[0] !== {{16{8'hC3}}, 2'b00}) begin errors++; $display("FAIL replay_key0: got %h expected c3..c3 then 00", obs_k[0]); end
    core_respond(1, '0, '0);
    consume();
  endtask

`ifdef ASCON_HOST_DECRYPT_EN
  task automatic test_decrypt();
    int es_seen;
    set_inputs(8'h77);
    use_dec = 1; auth_set = 0; mode_in = 1;
    send_job();
    mode_in = 0;
    collect_shift();
    checks++; if ({enc_start_so, dec_start_so} !== 2'b01) begin errors++; $display("FAIL dec_start: got %b expected 01", {enc_start_so, dec_start_so}); end
    es_seen = es_cnt + int'(enc_start_so);
    core_respond(3, 128'h0, 128'h1234_5678_9ABC_DEF0_0000_0000_0000_0001);
    checks++; if (es_seen !== 0 || enc_start_so !== 1'b0 || dec_start_so !== 1'b0) begin errors++; $display("FAIL dec_enc_quiet: got %0d/%b/%b expected 0/0/0", es_seen, enc_start_so, dec_start_so); end
    checks++; if (auth_out !== 1'b0) begin errors++; $display("FAIL auth_out: got %b expected 0", auth_out); end
    checks++; if (tag_out !== 128'h1234_5678_9ABC_DEF0_0000_0000_0000_0001) begin errors++; $display("FAIL dec_tag: got %h expected 123456789abcdef0..01", tag_out); end
    consume();
    use_dec = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_shift();
    test_capture();
    test_done_stall();
    test_back_to_back();
    test_timeout();
`ifdef ASCON_HOST_DECRYPT_EN
    test_decrypt();
`endif
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
